// File: rtl/mips_pkg.sv
// Shared types for the MIPS result path: result bundle layout, serializer states, beat helpers.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_OUT = 4;
    localparam int BEAT_W  = $clog2(NUM_OUT);

    typedef struct packed {
        logic                            fail;
        logic [NUM_OUT-1:0][DATA_W-1:0]  w;
    } res_bundle_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic logic is_last_beat(input logic [BEAT_W-1:0] idx);
        return idx == BEAT_W'(NUM_OUT - 1);
    endfunction

endpackage

// File: rtl/mips_res_fifo.sv
// Synchronous FIFO of result bundles; a push is accepted when full if a pop happens in the same cycle.
// Also exposes the entry that will sit at the head after the coming edge, so the consumer can register it.
module mips_res_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  res_bundle_t              push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output res_bundle_t              head_next,
    output logic                     empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    res_bundle_t     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   rd_ptr_s;
    logic [PW-1:0]   level_s;
    logic            do_push_s;
    logic            do_pop_s;

    // Occupancy comes from the extra pointer bit, so full and empty stay distinct.
    assign level      = wr_ptr_r - rd_ptr_r;
    assign full       = (level == PW'(DEPTH));
    assign empty      = (level == {PW{1'b0}});
    assign do_pop_s   = pop & ~empty;
    assign do_push_s  = push & (~full | do_pop_s);
    assign rd_ptr_s   = rd_ptr_r + PW'(do_pop_s);
    assign level_s    = level + PW'(do_push_s) - PW'(do_pop_s);
    assign empty_next = (level_s == {PW{1'b0}});

    // Next head: bypass the incoming bundle when the head slot is the one being written now.
    always_comb begin
        if (rd_ptr_s == wr_ptr_r) begin
            head_next = push_data;
        end else begin
            head_next = mem_r[rd_ptr_s[AW-1:0]];
        end
    end

    // Bundle storage write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(do_push_s);
            rd_ptr_r <= rd_ptr_s;
        end
    end

endmodule

// File: rtl/mips_result_serializer.sv
// Captures MIPS core result bundles into a FIFO and replays them as a 32-bit valid/ready beat stream.
// Build option: define RES_FAIL_FILTER_EN to discard failed bundles instead of emitting a fail beat.
module mips_result_serializer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     res_valid,
    input  logic                     res_fail,
    input  logic [DATA_W-1:0]        res_w1,
    input  logic [DATA_W-1:0]        res_w2,
    input  logic [DATA_W-1:0]        res_w3,
    input  logic [DATA_W-1:0]        res_w4,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_fail,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);

    import mips_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    res_bundle_t        push_bundle_s;
    res_bundle_t        head_next_s;
    logic               wr_en_s;
    logic               push_s;
    logic               pop_s;
    logic               hs_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               empty_next_s;
    logic [LW-1:0]      fifo_level_s;
    ser_state_e         state_r;
    ser_state_e         state_s;
    logic [BEAT_W-1:0]  idx_r;
    logic [BEAT_W-1:0]  idx_s;
    logic               valid_s;
    logic               fail_s;
    logic               last_s;
    logic [DATA_W-1:0]  data_s;

    assign push_bundle_s.w[0] = res_w1;
    assign push_bundle_s.w[1] = res_w2;
    assign push_bundle_s.w[2] = res_w3;
    assign push_bundle_s.w[3] = res_w4;

`ifdef RES_FAIL_FILTER_EN
    assign push_bundle_s.fail = 1'b0;
    assign wr_en_s            = res_valid & ~res_fail;
`else
    assign push_bundle_s.fail = res_fail;
    assign wr_en_s            = res_valid;
`endif

    assign hs_s   = m_valid & m_ready;
    assign pop_s  = hs_s & m_last & ~fifo_empty_s;
    assign drop_s = wr_en_s & fifo_full_s & ~pop_s;
    assign push_s = wr_en_s & ~drop_s;
    assign level  = fifo_level_s;

    mips_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_data  (push_bundle_s),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .level      (fifo_level_s),
        .head_next  (head_next_s),
        .empty_next (empty_next_s)
    );

    // Next state, beat index and the beat to present after the coming edge.
    always_comb begin
        state_s = IDLE;
        idx_s   = {BEAT_W{1'b0}};
        valid_s = 1'b0;
        data_s  = {DATA_W{1'b0}};
        fail_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                idx_s = {BEAT_W{1'b0}};
            end
            SEND: begin
                if (hs_s && m_last) begin
                    idx_s = {BEAT_W{1'b0}};
                end else if (hs_s) begin
                    idx_s = idx_r + BEAT_W'(1);
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                idx_s = {BEAT_W{1'b0}};
            end
        endcase
        // Without a handshake the head and index are unchanged, so a stalled beat is re-registered as-is.
        if (!empty_next_s) begin
            state_s = SEND;
            valid_s = 1'b1;
            if (head_next_s.fail) begin
                fail_s = 1'b1;
                last_s = 1'b1;
            end else begin
                data_s = head_next_s.w[idx_s];
                last_s = is_last_beat(idx_s);
            end
        end else begin
            state_s = IDLE;
            idx_s   = {BEAT_W{1'b0}};
        end
    end

    // FSM state, beat index and registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {BEAT_W{1'b0}};
            m_valid <= 1'b0;
            m_data  <= {DATA_W{1'b0}};
            m_fail  <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            m_valid <= valid_s;
            m_data  <= data_s;
            m_fail  <= fail_s;
            m_last  <= last_s;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= {CNT_W{1'b0}};
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule
